// File: rtl/edge_pkg.sv
// Shared types for the multi-channel edge detector: per-channel debounce state
// and the 2-bit edge-select encoding.
package edge_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'b00,
        RISE_WAIT = 2'b01,
        HIGH      = 2'b10,
        FALL_WAIT = 2'b11
    } edge_state_t;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_t;

    // Bit 0 of the mode enables rising edges, bit 1 enables falling edges.
    function automatic logic edge_enabled(input edge_mode_t m, input logic is_rise);
        return is_rise ? m[0] : m[1];
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One edge-detector channel: synchroniser chain, debounce counter, Mealy edge FSM
// and sticky pending flag.
//
//   state     | meaning
//   ----------|---------------------------------------------------------
//   LOW       | accepted level is 0, synced input agrees
//   RISE_WAIT | accepted level is 0, counting consecutive synced 1s
//   HIGH      | accepted level is 1, synced input agrees
//   FALL_WAIT | accepted level is 1, counting consecutive synced 0s
module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       level,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       tick,
    output logic       level_db,
    output logic       pending
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    edge_state_t            state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   rise_evt, fall_evt;
    edge_mode_t             mode_e;

    assign s      = sync_q[SYNC_STAGES-1];
    assign mode_e = edge_mode_t'(mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], level};
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rise_evt   = 1'b0;
        fall_evt   = 1'b0;
        tick       = 1'b0;
        case (state_reg)
            LOW: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = HIGH;
                        rise_evt   = 1'b1;
                    end else begin
                        state_next = RISE_WAIT;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            RISE_WAIT: begin
                if (!s) begin
                    state_next = LOW;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                    rise_evt   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            HIGH: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = LOW;
                        fall_evt   = 1'b1;
                    end else begin
                        state_next = FALL_WAIT;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            FALL_WAIT: begin
                if (s) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = LOW;
                    cnt_next   = '0;
                    fall_evt   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = LOW;
                cnt_next   = '0;
            end
        endcase
        tick = (rise_evt & edge_enabled(mode_e, 1'b1)) |
               (fall_evt & edge_enabled(mode_e, 1'b0));
    end

    // level_db is registered from the next state so it changes together with state_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= LOW;
            cnt_reg   <= '0;
            level_db  <= 1'b0;
            pending   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_db  <= (state_next == HIGH) || (state_next == FALL_WAIT);
            pending   <= tick | (pending & ~clr);
        end
    end

endmodule

// File: rtl/edge_detector_multi.sv
// N-channel edge detector for asynchronous level inputs; each channel is an
// independent edge_chan, with a combined pending flag for interrupt aggregation.
module edge_detector_multi
    import edge_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   level,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   clr,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   level_db,
    output logic [N_CH-1:0]   pending,
    output logic              any_pending
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .level   (level[i]),
            .mode    (mode[2*i+1:2*i]),
            .clr     (clr[i]),
            .tick    (tick[i]),
            .level_db(level_db[i]),
            .pending (pending[i])
        );
    end

    assign any_pending = |pending;

endmodule
